// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP word and
// default instruction width.
package ifetch_pkg;

  localparam int IFETCH_DW = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    REQ  = S_REQ,
    DONE = S_DONE
  } state_t;

  // Word handed to the IR when a fetch is abandoned by the watchdog.
  localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/ifetch_if.sv
// Request/acknowledge read bus between the fetch stage (master) and the
// instruction memory (slave).
interface ifetch_if import ifetch_pkg::*; #(
  parameter int AW = 8,
  parameter int DW = IFETCH_DW
) ();

  logic [AW-1:0] addr;
  logic          req;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output addr, output req, input ack, input rdata);
  modport slave  (input addr, input req, output ack, output rdata);

endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter for the fetch stage: direct loads in IDLE, pending jump capture
// while a read is outstanding, and increment or redirect when the read completes.
module pc_reg import ifetch_pkg::*; #(
  parameter int          AW     = 8,
  parameter int unsigned RST_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_idle,
  input  logic          in_req,
  input  logic          complete,
  input  logic          abort,
  input  logic          ld,
  input  logic [AW-1:0] tgt,
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] pc
);

  logic          pend;
  logic [AW-1:0] pend_tgt;

  // NOTE: registers update with non-blocking assignments so every branch below
  // sees the pre-edge values of pc, pend and pend_tgt.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= AW'(RST_PC);
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      if (in_idle && ld)
        pc <= tgt;
      if (in_req) begin
        if (complete) begin
          // A jump arriving with the ack beats an older pending one.
          if (ld)
            pc <= tgt;
          else if (pend)
            pc <= pend_tgt;
          else
            pc <= addr + 1'b1;
          pend <= 1'b0;
        end else if (abort) begin
          pend <= 1'b0;
        end else if (ld) begin
          pend     <= 1'b1;
          pend_tgt <= tgt;
        end
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: IDLE/REQ/DONE read sequencer feeding the IR.
// Define IFETCH_TIMEOUT_EN to add the ack watchdog and sticky err flag.
module ifetch import ifetch_pkg::*; #(
  parameter int          AW      = 8,
  parameter int          DW      = IFETCH_DW,
  parameter int unsigned RST_PC  = 0,
  parameter int          TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch,
  input  logic          pc_ld,
  input  logic [AW-1:0] pc_tgt,
  ifetch_if.master      mem,
  output logic [DW-1:0] d_out,
  output logic          ir_ld,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          err
);

  state_t state;
  logic   in_idle;
  logic   in_req;
  logic   complete;
  logic   abort;

  assign in_idle  = (state == IDLE);
  assign in_req   = (state == REQ);
  assign complete = in_req && mem.ack;

`ifdef IFETCH_TIMEOUT_EN
  logic [3:0] wdog;

  // An ack on the limit cycle takes priority over the watchdog.
  assign abort = in_req && !mem.ack && (wdog == 4'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  pc_reg #(
    .AW     (AW),
    .RST_PC (RST_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .in_idle  (in_idle),
    .in_req   (in_req),
    .complete (complete),
    .abort    (abort),
    .ld       (pc_ld),
    .tgt      (pc_tgt),
    .addr     (mem.addr),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem.addr <= '0;
      mem.req  <= 1'b0;
      d_out    <= '0;
      ir_ld    <= 1'b0;
      busy     <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      wdog     <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fetch) begin
            mem.addr <= pc_ld ? pc_tgt : pc;
            mem.req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
`ifdef IFETCH_TIMEOUT_EN
            wdog     <= '0;
`endif
          end
        end
        REQ: begin
          if (mem.ack) begin
            d_out   <= mem.rdata;
            mem.req <= 1'b0;
            ir_ld   <= 1'b1;
            state   <= DONE;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (abort) begin
            d_out   <= DW'(NOP);
            mem.req <= 1'b0;
            ir_ld   <= 1'b1;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            wdog <= wdog + 4'd1;
          end
`endif
        end
        DONE: begin
          ir_ld <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table of back-to-back fetches plus
// hand-written jump, reset, wrap and watchdog sequences; d_out scoreboarded on ir_ld.
module tb_ifetch;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch, pc_ld;
  logic [7:0]  pc_tgt;
  logic [15:0] d_out;
  logic        ir_ld;
  logic [7:0]  pc;
  logic        busy, err;

  logic        rst1, fetch1, pc_ld1;
  logic [7:0]  pc_tgt1;
  logic [15:0] d_out1;
  logic        ir_ld1;
  logic [7:0]  pc1;
  logic        busy1, err1;

  ifetch_if #(.AW(8), .DW(16)) bus0 ();
  ifetch_if #(.AW(8), .DW(16)) bus1 ();

  ifetch #(.AW(8), .DW(16), .RST_PC(0), .TIMEOUT(15)) dut0 (
    .clk(clk), .rst(rst), .fetch(fetch), .pc_ld(pc_ld), .pc_tgt(pc_tgt),
    .mem(bus0), .d_out(d_out), .ir_ld(ir_ld), .pc(pc), .busy(busy), .err(err)
  );

  ifetch #(.AW(8), .DW(16), .RST_PC(255), .TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst1), .fetch(fetch1), .pc_ld(pc_ld1), .pc_tgt(pc_tgt1),
    .mem(bus1), .d_out(d_out1), .ir_ld(ir_ld1), .pc(pc1), .busy(busy1), .err(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ir_ld pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (ir_ld === 1'b1) begin
      if (sbq.size() == 0)
        check("ir_ld_spurious", ir_ld, 1'b0);
      else
        check("d_out", d_out, sbq.pop_front());
    end
  end

  typedef struct {
    logic [15:0] word;
    int          delay;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic do_fetch(input logic [15:0] word, input int delay,
                          input logic [7:0] exp_addr, input logic [7:0] exp_pc,
                          input logic ld_fetch, input logic [7:0] ld_fetch_tgt,
                          input logic ld_req, input logic [7:0] ld_req_tgt,
                          input logic hold_fetch);
    fetch  = 1'b1;
    pc_ld  = ld_fetch;
    pc_tgt = ld_fetch_tgt;
    sbq.push_back(word);
    @(negedge clk);
    fetch = hold_fetch;
    pc_ld = 1'b0;
    check("req_rise", bus0.req, 1'b1);
    check("addr", bus0.addr, exp_addr);
    check("busy_req", busy, 1'b1);
    for (int i = 0; i < delay; i++) begin
      if (ld_req) begin
        pc_ld  = (i == 0) || (i == delay - 1);
        pc_tgt = (i == delay - 1) ? ld_req_tgt : (ld_req_tgt ^ 8'h0F);
      end
      @(negedge clk);
      pc_ld = 1'b0;
      check("req_hold", bus0.req, 1'b1);
      check("addr_stable", bus0.addr, exp_addr);
      check("no_early_ir_ld", ir_ld, 1'b0);
    end
    bus0.ack   = 1'b1;
    bus0.rdata = word;
    @(negedge clk);
    bus0.ack   = 1'b0;
    bus0.rdata = word ^ 16'hDEAD;
    check("req_drop", bus0.req, 1'b0);
    check("ir_ld_pulse", ir_ld, 1'b1);
    check("busy_done", busy, 1'b1);
    @(negedge clk);
    fetch = 1'b0;
    check("ir_ld_one_cycle", ir_ld, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("no_fetch_in_done", bus0.req, 1'b0);
    check("pc_after", pc, exp_pc);
    check("d_out_hold", d_out, word);
  endtask

  task automatic reset_dut0();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; fetch = 1'b0; pc_ld = 1'b0; pc_tgt = '0;
    rst1 = 1'b1; fetch1 = 1'b0; pc_ld1 = 1'b0; pc_tgt1 = '0;
    bus0.ack = 1'b0; bus0.rdata = '0;
    bus1.ack = 1'b0; bus1.rdata = '0;

    vecs[0] = '{16'h00B1, 0, 8'h00, 8'h01};
    vecs[1] = '{16'h1131, 1, 8'h01, 8'h02};
    vecs[2] = '{16'h00B1, 2, 8'h02, 8'h03};
    vecs[3] = '{16'h80B1, 3, 8'h03, 8'h04};
    vecs[4] = '{16'hC0B1, 4, 8'h04, 8'h05};

    repeat (2) @(negedge clk);
    check("rst_req", bus0.req, 1'b0);
    check("rst_addr", bus0.addr, 8'h00);
    check("rst_pc", pc, 8'h00);
    check("rst_d_out", d_out, 16'h0000);
    check("rst_ir_ld", ir_ld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_pc_ff", pc1, 8'hFF);
    rst = 1'b0; rst1 = 1'b0;

    // Single fetch, ack one cycle after mem_req rises.
    do_fetch(16'h00B1, 0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Back-to-back fetches from the vector table.
    reset_dut0();
    for (int v = 0; v < 5; v++)
      do_fetch(vecs[v].word, vecs[v].delay, vecs[v].exp_addr, vecs[v].exp_pc,
               1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Jump during REQ (last pc_ld wins), fetch held high while busy is ignored.
    do_fetch(16'h2222, 3, 8'h05, 8'h40, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1);
    do_fetch(16'h3333, 1, 8'h40, 8'h41, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // pc_ld alone in IDLE.
    pc_ld = 1'b1; pc_tgt = 8'h20;
    @(negedge clk);
    pc_ld = 1'b0;
    check("idle_pc_ld", pc, 8'h20);
    check("idle_pc_ld_no_req", bus0.req, 1'b0);

    // fetch and pc_ld in the same IDLE cycle.
    do_fetch(16'h4444, 0, 8'h10, 8'h11, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0);

    // Reset while waiting in REQ; a late ack must be ignored.
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    check("rst_mid_req_pre", bus0.req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req", bus0.req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_pc", pc, 8'h00);
    bus0.ack = 1'b1; bus0.rdata = 16'hBEEF;
    @(negedge clk);
    bus0.ack = 1'b0;
    check("late_ack_ir_ld", ir_ld, 1'b0);
    check("late_ack_d_out", d_out, 16'h0000);
    @(negedge clk);
    check("late_ack_ir_ld2", ir_ld, 1'b0);

    // Wrap at RST_PC=0xFF.
    fetch1 = 1'b1;
    @(negedge clk);
    fetch1 = 1'b0;
    check("wrap_addr", bus1.addr, 8'hFF);
    bus1.ack = 1'b1; bus1.rdata = 16'h5A5A;
    @(negedge clk);
    bus1.ack = 1'b0;
    check("wrap_ir_ld", ir_ld1, 1'b1);
    check("wrap_d_out", d_out1, 16'h5A5A);
    @(negedge clk);
    check("wrap_pc", pc1, 8'h00);

    // Ack on the 15th waiting edge: the ack wins over any watchdog.
    do_fetch(16'hABCD, 14, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("ack_boundary_err", err, 1'b0);

`ifdef IFETCH_TIMEOUT_EN
    fetch = 1'b1;
    sbq.push_back(NOP);
    cnt = 0;
    @(negedge clk);
    fetch = 1'b0;
    cnt = 1;
    while (ir_ld !== 1'b1 && cnt < 24) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, 16);
    check("timeout_err", err, 1'b1);
    check("timeout_req", bus0.req, 1'b0);
    check("timeout_pc", pc, 8'h01);
    repeat (3) @(negedge clk);
    check("timeout_ir_ld_off", ir_ld, 1'b0);
    check("err_sticky", err, 1'b1);
    do_fetch(16'h7777, 0, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("err_sticky_after_fetch", err, 1'b1);
`else
    do_fetch(16'h7777, 20, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("no_timeout_err", err, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
